add_serial: RTL and testbench



---
 rtl/add_serial.sv | 109 ++++++++++
 tb/tb_add_serial.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// ============================================================================
//  Module      : add_serial
//  Description : Multi-cycle adder/subtractor that walks one CHUNK-bit carry
//                slice across WIDTH-bit operands, LSB chunk first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   part_q;
  logic               carry_q;
  logic               sub_q;

  logic [CHUNK-1:0]   a_sl_d;
  logic [CHUNK-1:0]   b_sl_d;
  logic [CHUNK:0]     sum_d;
  logic [WIDTH-1:0]   part_d;
  logic               cmsb_d;

  // One carry-chain slice shared by every chunk position.
  always_comb begin
    a_sl_d = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    b_sl_d = b_q[int'(cnt_q) * CHUNK +: CHUNK];
    sum_d  = {1'b0, a_sl_d} + {1'b0, b_sl_d} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit; only the last chunk's value is used.
    cmsb_d = sum_d[CHUNK-1] ^ a_sl_d[CHUNK-1] ^ b_sl_d[CHUNK-1];
    part_d = part_q;
    part_d[int'(cnt_q) * CHUNK +: CHUNK] = sum_d[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in_1;
            b_q     <= sub ? ~in_2 : in_2;
            carry_q <= sub;
            sub_q   <= sub;
            cnt_q   <= '0;
            part_q  <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q  <= part_d;
          carry_q <= sum_d[CHUNK];
          if (cnt_q == LAST) begin
            // Subtraction reports borrow, the inverse of the final carry.
            out      <= {sub_q ? ~sum_d[CHUNK] : sum_d[CHUNK], part_d};
            overflow <= cmsb_d ^ sum_d[CHUNK];
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_serial.sv
// ============================================================================
//  Module      : tb_add_serial
//  Description : Self-checking bench for add_serial over four configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  start_v = '0;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  ovf_v;
  logic [8:0]  out0, out1, out2;
  logic [16:0] out3;
  logic [16:0] out_v [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign out_v[0] = {8'd0, out0};
  assign out_v[1] = {8'd0, out1};
  assign out_v[2] = {8'd0, out2};
  assign out_v[3] = out3;

  add_serial #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub),
    .in_1(in_a[7:0]), .in_2(in_b[7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .out(out0), .overflow(ovf_v[0]));

  add_serial #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub),
    .in_1(in_a[7:0]), .in_2(in_b[7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .out(out1), .overflow(ovf_v[1]));

  add_serial #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub),
    .in_1(in_a[7:0]), .in_2(in_b[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .out(out2), .overflow(ovf_v[2]));

  add_serial #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub),
    .in_1(in_a), .in_2(in_b),
    .busy(busy_v[3]), .done(done_v[3]), .out(out3), .overflow(ovf_v[3]));

  function automatic int width_of(input int d);
    return (d == 3) ? 16 : 8;
  endfunction

  function automatic int lat_of(input int d);
    case (d)
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input logic s, input logic [15:0] x,
                                input logic [15:0] y, output logic [16:0] o,
                                output logic ov);
    longint mask, half, ux, uy, r, low, top, sx, sy, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    r    = s ? (ux - uy) : (ux + uy);
    low  = r & mask;
    top  = s ? ((ux < uy) ? 1 : 0) : ((r >> w) & 1);
    sx   = (ux >= half) ? ux - (half << 1) : ux;
    sy   = (uy >= half) ? uy - (half << 1) : uy;
    sr   = s ? (sx - sy) : (sx + sy);
    o    = 17'((top << w) | low);
    ov   = (sr < -half) || (sr > half - 1);
  endfunction

  task automatic run_op(input int d, input logic s, input logic [15:0] x,
                        input logic [15:0] y, output logic [16:0] o,
                        output logic ov, output int lat);
    @(negedge clk);
    sub = s; in_a = x; in_b = y; start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[d]) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      $display("FAIL done_timeout dut%0d: no done within 20 cycles, required %0d", d, lat_of(d));
      failures++;
    end
    o  = out_v[d];
    ov = ovf_v[d];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({busy_v[d], done_v[d], ovf_v[d]} !== 3'b000) begin
        $display("FAIL reset_flags dut%0d: busy/done/ovf=%b required 000", d,
                 {busy_v[d], done_v[d], ovf_v[d]});
        failures++;
      end
      checks++;
      if (out_v[d] !== 17'd0) begin
        $display("FAIL reset_out dut%0d: got %h required 0", d, out_v[d]);
        failures++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        s_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] x_t  [5] = '{16'd200, 16'd100, 16'hFF, 16'd5, 16'h80};
    logic [15:0] y_t  [5] = '{16'd100, 16'd100, 16'h01, 16'd10, 16'h01};
    logic [16:0] eo_t [5] = '{17'h12C, 17'h0C8, 17'h100, 17'h1FB, 17'h07F};
    logic        ev_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [16:0] o;
    logic        ov;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(0, s_t[i], x_t[i], y_t[i], o, ov, lat);
      checks++;
      if (o !== eo_t[i] || ov !== ev_t[i]) begin
        $display("FAIL directed_%0d: out=%h ovf=%b required out=%h ovf=%b", i, o, ov, eo_t[i], ev_t[i]);
        failures++;
      end
      checks++;
      if (lat != 4) begin
        $display("FAIL directed_latency_%0d: got %0d required 4", i, lat);
        failures++;
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    @(negedge clk);
    sub = 1'b0; in_a = 16'd200; in_b = 16'd100; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sub = 1'b1; in_a = 16'h11; in_b = 16'h22;
    checks++;
    if (busy_v[0] !== 1'b1) begin
      $display("FAIL busy_after_start: got %b required 1", busy_v[0]);
      failures++;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3) start_v[0] = 1'b0;
      if (done_v[0]) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 4 || out_v[0] !== 17'h12C || ovf_v[0] !== 1'b0) begin
      $display("FAIL ignore_start: lat=%0d out=%h ovf=%b required lat=4 out=12c ovf=0", lat, out_v[0], ovf_v[0]);
      failures++;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      $display("FAIL ignore_start_idle: busy=%b done=%b required 0 0", busy_v[0], done_v[0]);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] o;
    logic        ov;
    int          lat;
    run_op(0, 1'b0, 16'd100, 16'd100, o, ov, lat);
    checks++;
    if (o !== 17'h0C8 || ov !== 1'b1 || busy_v[0] !== 1'b0) begin
      $display("FAIL b2b_first: out=%h ovf=%b busy=%b required out=0c8 ovf=1 busy=0", o, ov, busy_v[0]);
      failures++;
    end
    // Still in the done cycle: launch the second operation now.
    sub = 1'b1; in_a = 16'h80; in_b = 16'h01; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      $display("FAIL b2b_accept: done=%b busy=%b required done=0 busy=1", done_v[0], busy_v[0]);
      failures++;
    end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0]) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 4 || out_v[0] !== 17'h07F || ovf_v[0] !== 1'b1) begin
      $display("FAIL b2b_second: lat=%0d out=%h ovf=%b required lat=4 out=07f ovf=1", lat, out_v[0], ovf_v[0]);
      failures++;
    end
  endtask

  task automatic test_reset_abort();
    logic [16:0] o;
    logic        ov;
    int          lat;
    int          dones = 0;
    @(negedge clk);
    sub = 1'b0; in_a = 16'hFF; in_b = 16'h01; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || out_v[0] !== 17'd0 || ovf_v[0] !== 1'b0) begin
      $display("FAIL reset_abort: busy=%b done=%b out=%h ovf=%b required all 0",
               busy_v[0], done_v[0], out_v[0], ovf_v[0]);
      failures++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    checks++;
    if (dones != 0) begin
      $display("FAIL abort_no_done: saw %0d done pulses required 0", dones);
      failures++;
    end
    run_op(0, 1'b0, 16'd3, 16'd4, o, ov, lat);
    checks++;
    if (o !== 17'd7 || ov !== 1'b0 || lat != 4) begin
      $display("FAIL after_abort: out=%h ovf=%b lat=%0d required out=7 ovf=0 lat=4", o, ov, lat);
      failures++;
    end
  endtask

  task automatic test_sweep();
    logic [16:0] o;
    logic        ov;
    int          lat;
    run_op(1, 1'b0, 16'h7F, 16'h01, o, ov, lat);
    checks++;
    if (o !== 17'h080 || ov !== 1'b1 || lat != 1) begin
      $display("FAIL chunk8: out=%h ovf=%b lat=%0d required out=080 ovf=1 lat=1", o, ov, lat);
      failures++;
    end
    run_op(2, 1'b1, 16'd5, 16'd10, o, ov, lat);
    checks++;
    if (o !== 17'h1FB || ov !== 1'b0 || lat != 8) begin
      $display("FAIL chunk1: out=%h ovf=%b lat=%0d required out=1fb ovf=0 lat=8", o, ov, lat);
      failures++;
    end
    run_op(3, 1'b0, 16'hFFFF, 16'h0001, o, ov, lat);
    checks++;
    if (o !== 17'h10000 || ov !== 1'b0 || lat != 4) begin
      $display("FAIL w16c4: out=%h ovf=%b lat=%0d required out=10000 ovf=0 lat=4", o, ov, lat);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [16:0] o, eo;
    logic        ov, ev, s;
    logic [15:0] x, y;
    int          lat;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 25; i++) begin
        x = 16'($urandom);
        y = 16'($urandom);
        s = 1'($urandom_range(0, 1));
        model(width_of(d), s, x, y, eo, ev);
        run_op(d, s, x, y, o, ov, lat);
        checks++;
        if (o !== eo || ov !== ev || lat != lat_of(d)) begin
          $display("FAIL random dut%0d sub=%b x=%h y=%h: out=%h ovf=%b lat=%0d required out=%h ovf=%b lat=%0d",
                   d, s, x, y, o, ov, lat, eo, ev, lat_of(d));
          failures++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
